// File: rtl/tmr_seq.sv
// tmr_seq: steps one tmr instance through a table of compare values without CPU help.
// Latency: start written at edge N -> TMR_RE write in N+1; tmr_irq seen at edge M -> TMR_IR clear in M+1, reload in M+2.
// Backpressure: none; the timer bus takes one write per cycle. Define TMR_SEQ_CNT_EN for the loop counter at 0x18.
module tmr_seq #(
  parameter int         tmr_w   = 8,
  parameter int         DEPTH   = 8,
  parameter logic [4:0] CR_ADDR = 5'h00,
  parameter logic [4:0] RE_ADDR = 5'h04,
  parameter logic [4:0] IR_ADDR = 5'h08
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq,
  output logic [4:0]  m_addr,
  output logic        m_we,
  output logic [31:0] m_wd,
  input  logic        tmr_irq
);

  localparam int IW = $clog2(DEPTH);
  localparam int LW = IW + 1;

  localparam logic [4:0] A_CR    = 5'h00;
  localparam logic [4:0] A_TCR   = 5'h04;
  localparam logic [4:0] A_LEN   = 5'h08;
  localparam logic [4:0] A_ST    = 5'h0C;
  localparam logic [4:0] A_TPTR  = 5'h10;
  localparam logic [4:0] A_TDATA = 5'h14;
  localparam logic [4:0] A_CNT   = 5'h18;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT_RE = 3'd1,
    INIT_CR = 3'd2,
    WAIT    = 3'd3,
    CLR_IR  = 3'd4,
    LOAD_RE = 3'd5,
    STOP    = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_loop;
  logic              r_ie;
  logic              r_done;
  logic [2:0]        r_tcr;
  logic [LW-1:0]     r_len;
  logic [IW-1:0]     r_idx;
  logic [IW-1:0]     w_idx_nxt;
  logic [IW-1:0]     r_tptr;
  logic [tmr_w-1:0]  r_tab [DEPTH];

  logic              w_cr_wr;
  logic              w_start;
  logic              w_abort;
  logic              w_busy;
  logic              w_set_done;
  logic              w_wrap;
  logic              w_more;
  logic [LW-1:0]     w_len_eff;
  logic              w_unused_wd;

  // Only a handful of write-data bits land in registers; the rest are don't-care.
  assign w_unused_wd = ^wd;

  assign w_cr_wr = we && (addr == A_CR);
  // Abort written together with start suppresses the start.
  assign w_start = w_cr_wr && wd[0] && !wd[3];
  assign w_abort = w_cr_wr && wd[3];
  assign w_busy  = (r_state != IDLE);
  assign irq     = r_done & r_ie;

  // Clamp the programmed length into 1..DEPTH.
  always_comb begin
    w_len_eff = r_len;
    if (r_len == '0) begin
      w_len_eff = LW'(1);
    end else if (r_len > LW'(DEPTH)) begin
      w_len_eff = LW'(DEPTH);
    end
  end

  // True while the current step is not the last active table entry.
  assign w_more = (({1'b0, r_idx} + LW'(1)) < w_len_eff);

  // Sequencer state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, step index and timer-bus access for the current state.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_set_done  = 1'b0;
    w_wrap      = 1'b0;
    m_we        = 1'b0;
    m_addr      = '0;
    m_wd        = '0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_idx_nxt   = '0;
          w_state_nxt = INIT_RE;
        end
      end
      INIT_RE: begin
        m_we        = 1'b1;
        m_addr      = RE_ADDR;
        m_wd        = 32'(r_tab[0]);
        w_state_nxt = INIT_CR;
      end
      INIT_CR: begin
        m_we        = 1'b1;
        m_addr      = CR_ADDR;
        m_wd        = 32'(r_tcr);
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (tmr_irq) begin
          w_state_nxt = CLR_IR;
        end
      end
      CLR_IR: begin
        m_we   = 1'b1;
        m_addr = IR_ADDR;
        m_wd   = '0;
        if (w_more) begin
          w_idx_nxt   = r_idx + IW'(1);
          w_state_nxt = LOAD_RE;
        end else if (r_loop) begin
          w_idx_nxt   = '0;
          w_wrap      = 1'b1;
          w_state_nxt = LOAD_RE;
        end else begin
          w_set_done  = 1'b1;
          w_state_nxt = STOP;
        end
      end
      LOAD_RE: begin
        m_we        = 1'b1;
        m_addr      = RE_ADDR;
        m_wd        = 32'(r_tab[r_idx]);
        w_state_nxt = WAIT;
      end
      STOP: begin
        m_we        = 1'b1;
        m_addr      = CR_ADDR;
        m_wd        = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Abort overrides any progress made this cycle; STOP still stops the timer.
    if (w_abort && (r_state != IDLE) && (r_state != STOP)) begin
      w_state_nxt = STOP;
      w_idx_nxt   = r_idx;
      w_set_done  = 1'b0;
      w_wrap      = 1'b0;
    end
  end

  // Step index follows the FSM's choice.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx <= '0;
    end else begin
      r_idx <= w_idx_nxt;
    end
  end

  // Software-visible control registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_loop <= 1'b0;
      r_ie   <= 1'b0;
      r_tcr  <= '0;
      r_len  <= '0;
    end else if (we) begin
      case (addr)
        A_CR: begin
          r_loop <= wd[1];
          r_ie   <= wd[2];
        end
        A_TCR:   r_tcr <= wd[2:0];
        A_LEN:   r_len <= wd[LW-1:0];
        default: ;
      endcase
    end
  end

  // Done flag: a same-cycle set beats a software clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_done <= 1'b0;
    end else if (w_set_done) begin
      r_done <= 1'b1;
    end else if (we && (addr == A_ST) && wd[1]) begin
      r_done <= 1'b0;
    end
  end

  // Step table and its auto-incrementing write pointer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tab[i] <= '0;
      end
    end else if (we && (addr == A_TPTR)) begin
      r_tptr <= wd[IW-1:0];
    end else if (we && (addr == A_TDATA)) begin
      r_tab[r_tptr] <= wd[tmr_w-1:0];
      r_tptr        <= r_tptr + IW'(1);
    end
  end

`ifdef TMR_SEQ_CNT_EN
  logic [15:0] r_cnt;

  // Counts completed passes through the table in loop mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (w_start && (r_state == IDLE)) begin
      r_cnt <= '0;
    end else if (w_wrap && (r_cnt != 16'hFFFF)) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end
`endif

  // Slave read mux; unmapped addresses read zero.
  always_comb begin
    rd = '0;
    case (addr)
      A_CR:    rd = {29'd0, r_ie, r_loop, 1'b0};
      A_TCR:   rd = 32'(r_tcr);
      A_LEN:   rd = 32'(r_len);
      A_ST:    rd = {16'd0, 8'(r_idx), 6'd0, r_done, w_busy};
      A_TPTR:  rd = 32'(r_tptr);
      A_TDATA: rd = 32'(r_tab[r_tptr]);
`ifdef TMR_SEQ_CNT_EN
      A_CNT:   rd = 32'(r_cnt);
`else
      A_CNT:   rd = '0;
`endif
      default: rd = '0;
    endcase
  end

endmodule

// File: tb/tb_tmr_seq.sv
// Bench for tmr_seq: scoreboard of expected timer-bus writes checked by a monitor each cycle.
// Stimulus: directed table runs plus randomized length/loop/abort runs against a step-count model.
// The timer is emulated by holding tmr_irq until the sequencer clears it over the bus.
module tb_tmr_seq;
  localparam int DEPTH = 8;
  localparam int TW    = 8;

  localparam logic [4:0] A_CR    = 5'h00;
  localparam logic [4:0] A_TCR   = 5'h04;
  localparam logic [4:0] A_LEN   = 5'h08;
  localparam logic [4:0] A_ST    = 5'h0C;
  localparam logic [4:0] A_TPTR  = 5'h10;
  localparam logic [4:0] A_TDATA = 5'h14;
  localparam logic [4:0] A_CNT   = 5'h18;
  localparam logic [4:0] T_CR    = 5'h00;
  localparam logic [4:0] T_RE    = 5'h04;
  localparam logic [4:0] T_IR    = 5'h08;

  logic        clk;
  logic        rstn;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        irq;
  logic [4:0]  m_addr;
  logic        m_we;
  logic [31:0] m_wd;
  logic        tmr_irq;

  tmr_seq #(
    .tmr_w(TW), .DEPTH(DEPTH), .CR_ADDR(T_CR), .RE_ADDR(T_RE), .IR_ADDR(T_IR)
  ) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .we(we), .wd(wd), .rd(rd), .irq(irq),
    .m_addr(m_addr), .m_we(m_we), .m_wd(m_wd), .tmr_irq(tmr_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Expected timer-bus writes, in order.
  logic [4:0]  qa[$];
  logic [31:0] qd[$];

  // Reference model of the programmed state.
  logic [TW-1:0] mtab [DEPTH];
  int            mptr;
  int            mlen;
  int            mk;
  bit            mloop;
  bit            mie;
  bit            mdone;
  logic [2:0]    mtcr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    qa.push_back(a);
    qd.push_back(d);
  endtask

  function automatic int eff_len();
    if (mlen == 0) return 1;
    if (mlen > DEPTH) return DEPTH;
    return mlen;
  endfunction

  function automatic logic [31:0] exp_st();
    int L;
    int idx;
    L   = eff_len();
    idx = mloop ? (mk % L) : ((mk < L) ? mk : L - 1);
    return (32'(idx) << 8) | (32'(mdone) << 1);
  endfunction

  function automatic logic [31:0] cnt_exp();
`ifdef TMR_SEQ_CNT_EN
    return mloop ? 32'(mk / eff_len()) : 32'd0;
`else
    return 32'd0;
`endif
  endfunction

  // Monitor: every cycle the bus either carries the next expected write or is all-zero.
  initial begin
    forever begin
      @(negedge clk);
      if (m_we === 1'b1) begin
        if (qa.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL bus_extra: got write addr 0x%0h data 0x%0h, expected no write at %0t",
                   m_addr, m_wd, $time);
        end else begin
          check("bus_addr", 32'(m_addr), 32'(qa.pop_front()));
          check("bus_data", m_wd, qd.pop_front());
        end
      end else begin
        check("quiet_we", 32'(m_we), 32'd0);
        check("quiet_addr", 32'(m_addr), 32'd0);
        check("quiet_data", m_wd, 32'd0);
      end
    end
  end

  task automatic bwr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    addr = a;
    wd   = d;
    we   = 1'b1;
    @(negedge clk);
    we   = 1'b0;
    addr = '0;
    wd   = '0;
  endtask

  task automatic brd(input logic [4:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d    = rd;
    addr = '0;
  endtask

  task automatic tab_put(input logic [31:0] v);
    bwr(A_TDATA, v);
    mtab[mptr] = v[TW-1:0];
    mptr       = (mptr + 1) % DEPTH;
  endtask

  task automatic tab_write(input int ptr, input int n);
    bwr(A_TPTR, 32'(ptr));
    mptr = ptr % DEPTH;
    for (int i = 0; i < n; i++) tab_put($urandom);
  endtask

  task automatic start_seq(input bit lp, input bit ie);
    mloop = lp;
    mie   = ie;
    mk    = 0;
    push(T_RE, 32'(mtab[0]));
    push(T_CR, 32'(mtcr));
    bwr(A_CR, {29'd0, ie, lp, 1'b1});
    check("start_latency", {26'd0, m_we, m_addr}, {26'd0, 1'b1, T_RE});
  endtask

  // One timer match: hold tmr_irq until the sequencer writes TMR_IR.
  task automatic fire();
    int L;
    bit got;
    got = 1'b0;
    L   = eff_len();
    mk++;
    push(T_IR, 32'd0);
    if (mloop) push(T_RE, 32'(mtab[mk % L]));
    else if (mk < L) push(T_RE, 32'(mtab[mk]));
    else begin
      push(T_CR, 32'd0);
      mdone = 1'b1;
    end
    @(negedge clk);
    tmr_irq = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (m_we === 1'b1 && m_addr == T_IR) begin
        got = 1'b1;
        break;
      end
    end
    tmr_irq = 1'b0;
    check("irq_serviced", 32'(got), 32'd1);
  endtask

  task automatic abort_seq();
    logic [31:0] v;
    push(T_CR, 32'd0);
    bwr(A_CR, {28'd0, 1'b1, mie, mloop, 1'b0});
    check("abort_stop", {26'd0, m_we, m_addr}, {26'd0, 1'b1, T_CR});
    @(negedge clk);
    brd(A_ST, v);
    check("abort_busy", 32'(v[0]), 32'd0);
    check("abort_done", 32'(v[1]), 32'(mdone));
  endtask

  task automatic wait_idle();
    logic [31:0] v;
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 60; t++) begin
      brd(A_ST, v);
      if (v[0] == 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic clear_done();
    logic [31:0] v;
    bwr(A_ST, 32'h2);
    mdone = 1'b0;
    check("irq_cleared", 32'(irq), 32'd0);
    brd(A_ST, v);
    check("done_cleared", 32'(v[1]), 32'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mtab[i] = '0;
    mptr  = 0;
    mlen  = 0;
    mk    = 0;
    mloop = 1'b0;
    mie   = 1'b0;
    mdone = 1'b0;
    mtcr  = '0;
  endtask

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    rstn    = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wd      = '0;
    tmr_irq = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_m_we", 32'(m_we), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    brd(A_ST, v);
    check("rst_st", v, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    brd(A_TDATA, v);
    check("rst_tab", v, 32'd0);

    // Single pass: 10, 20, 30 with TCR=7, ie set.
    bwr(A_TPTR, 32'd0);
    mptr = 0;
    tab_put(32'd10);
    tab_put(32'd20);
    tab_put(32'd30);
    bwr(A_LEN, 32'd3);
    mlen = 3;
    bwr(A_TCR, 32'h7);
    mtcr = 3'b111;
    start_seq(1'b0, 1'b1);
    fire();
    @(negedge clk);
    brd(A_ST, v);
    check("st_step1", v, 32'h0101);
    fire();
    fire();
    @(negedge clk);
    check("irq_with_stop", 32'(irq), 32'd1);
    wait_idle();
    brd(A_ST, v);
    check("st_single_done", v, 32'h0202);
    clear_done();

    // Loop mode, two steps, four matches, then abort in WAIT.
    bwr(A_LEN, 32'd2);
    mlen = 2;
    start_seq(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) fire();
    brd(A_ST, v);
    check("loop_busy", 32'(v[0]), 32'd1);
    brd(A_CNT, v);
    check("loop_cnt", v, cnt_exp());
    repeat (2) @(negedge clk);
    abort_seq();
    brd(A_ST, v);
    check("loop_abort_st", v, exp_st());

    // Oversized length runs DEPTH steps; start while busy is ignored.
    tab_write(0, DEPTH);
    bwr(A_LEN, 32'(DEPTH + 5));
    mlen = DEPTH + 5;
    start_seq(1'b0, 1'b0);
    fire();
    bwr(A_CR, 32'h1);
    @(negedge clk);
    brd(A_ST, v);
    check("busy_start_ignored", v, 32'h0101);
    for (int i = 1; i < DEPTH; i++) fire();
    wait_idle();
    brd(A_ST, v);
    check("st_long_done", v, exp_st());
    check("irq_masked", 32'(irq), 32'd0);
    clear_done();

    // Randomized runs.
    for (int r = 0; r < 14; r++) begin
      int L;
      int nf;
      bit lp;
      bit ie;
      bit mid;
      tab_write($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH));
      mlen = $urandom_range(0, 2 * DEPTH - 1);
      bwr(A_LEN, 32'(mlen));
      brd(A_LEN, v);
      check("len_rb", v, 32'(mlen));
      v = $urandom;
      bwr(A_TCR, v);
      mtcr = v[2:0];
      brd(A_TCR, v);
      check("tcr_rb", v, 32'(mtcr));
      lp  = 1'($urandom_range(0, 1));
      ie  = 1'($urandom_range(0, 1));
      L   = eff_len();
      mid = !lp && (L > 1) && ($urandom_range(0, 2) == 0);
      nf  = lp ? int'($urandom_range(1, 2 * L + 1)) : (mid ? int'($urandom_range(1, L - 1)) : L);
      start_seq(lp, ie);
      for (int f = 0; f < nf; f++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        fire();
      end
      if (lp || mid) begin
        repeat (2) @(negedge clk);
        abort_seq();
      end
      wait_idle();
      brd(A_ST, v);
      check("st_final", v, exp_st());
      check("irq_final", 32'(irq), 32'(mdone & mie));
      brd(A_CNT, v);
      check("cnt_final", v, cnt_exp());
      if (mdone) clear_done();
    end

    // LEN=0 acts as one step; leave done set for the reset check.
    bwr(A_LEN, 32'd0);
    mlen = 0;
    start_seq(1'b0, 1'b1);
    fire();
    wait_idle();
    brd(A_ST, v);
    check("len0_done", v, exp_st());
    check("len0_irq", 32'(irq), 32'd1);

    // Reset while waiting for a match abandons the run without a STOP write.
    start_seq(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("pre_reset_irq", 32'(irq), 32'd1);
    rstn = 1'b0;
    #1;
    check("reset_m_we", 32'(m_we), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    brd(A_ST, v);
    check("reset_st", v, 32'd0);
    model_reset();
    check("queue_at_reset", 32'(qa.size()), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    brd(A_TCR, v);
    check("reset_tcr", v, 32'd0);
    repeat (3) @(negedge clk);
    check("queue_end", 32'(qa.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tmr_seq.md
# tmr_seq

Bus-programmable sequencer that drives one `tmr` instance through a table of compare values without CPU intervention. It sits between the system bus and the timer's register port. Software loads a step table and a timer control word, then starts the sequencer. The sequencer then programs TMR_RE, enables the timer, services each match interrupt, reloads the next compare value, and raises its own completion interrupt at the end of the table.

## Interface
Parameters:
- `tmr_w`, 8: width of timer compare values; must match the driven `tmr`.
- `DEPTH`, 8: number of step-table entries; power of two, 2..64.
- `CR_ADDR`, 5'h00: timer TMR_CR address.
- `RE_ADDR`, 5'h04: timer TMR_RE address.
- `IR_ADDR`, 5'h08: timer TMR_IR address.

Ports:
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `addr`, in, 5: slave register address.
- `we`, in, 1: slave write enable.
- `wd`, in, 32: slave write data.
- `rd`, out, 32: slave read data, combinational, zero-extended.
- `irq`, out, 1: sequence-done interrupt.
- `m_addr`, out, 5: timer bus address.
- `m_we`, out, 1: timer bus write strobe; one cycle per access.
- `m_wd`, out, 32: timer bus write data.
- `tmr_irq`, in, 1: timer `irq` output.

## Operation
Slave registers; unmapped reads return 0:
- 0x00 SEQ_CR:
  - [0] start: write-1 pulse, reads 0.
  - [1] loop.
  - [2] ie.
  - [3] abort: write-1 pulse, reads 0.
- 0x04 SEQ_TCR[2:0]: control word written to TMR_CR at start.
- 0x08 SEQ_LEN[$clog2(DEPTH):0]: active step count.
  - 0 is treated as 1.
  - Values above DEPTH are treated as DEPTH.
- 0x0C SEQ_ST, read-only except done:
  - [0] busy.
  - [1] done; write 1 clears it.
  - [15:8] current step index.
- 0x10 SEQ_TPTR: table pointer, modulo DEPTH.
- 0x14 SEQ_TDATA:
  - Write stores `wd[tmr_w-1:0]` to `tab[TPTR]`, then TPTR increments (wraps).
  - Read returns `tab[TPTR]`.
  - Table writes while busy are accepted and take effect at the next load.

FSM states: IDLE, INIT_RE, INIT_CR, WAIT, CLR_IR, LOAD_RE, STOP.
- IDLE: on start, idx←0, go to INIT_RE. Start while busy is ignored.
- INIT_RE: `m_addr=RE_ADDR`, `m_wd=tab[0]` → INIT_CR.
- INIT_CR: `m_addr=CR_ADDR`, `m_wd=SEQ_TCR` → WAIT.
- WAIT: on `tmr_irq`=1 → CLR_IR.
- CLR_IR: `m_addr=IR_ADDR`, `m_wd=0`. Then:
  - If idx < len-1: idx←idx+1, go to LOAD_RE.
  - Else if loop: idx←0, go to LOAD_RE.
  - Else go to STOP and set done.
- LOAD_RE: `m_addr=RE_ADDR`, `m_wd=tab[idx]` → WAIT.
- STOP: `m_addr=CR_ADDR`, `m_wd=0` → IDLE.

Abort:
- From any state other than IDLE/STOP, abort forces STOP next cycle.
- done is not set on abort.
- Abort in IDLE has no effect.
- Abort and start written together: abort wins.

Other rules:
- `irq = done & ie`.
- busy = (state != IDLE).
- `m_we` is 1 only in INIT_RE, INIT_CR, CLR_IR, LOAD_RE and STOP.
- `m_addr` and `m_wd` are 0 whenever `m_we`=0.

## Timing
- Reset values:
  - State IDLE, all registers 0, table contents 0.
  - Outputs: `irq`=0, `m_we`=0, `m_addr`=0, `m_wd`=0.
  - Reset mid-sequence abandons it with no STOP write.
- Start written at edge N:
  - INIT_RE write visible during cycle N+1.
  - INIT_CR write in N+2.
  - WAIT from N+3.
- `tmr_irq` sampled high at edge M (in WAIT):
  - CLR_IR in M+1.
  - LOAD_RE (or STOP) in M+2.
  - WAIT resumes at M+3.
- Timer irq clears after the CLR_IR write, so WAIT never re-triggers on a stale interrupt.
- done sets at the edge ending CLR_IR. `irq` rises the same cycle as STOP.
- A done clear written in the same cycle done sets: set wins.

## Configuration
- `TMR_SEQ_CNT_EN` defined:
  - 16-bit loop counter at 0x18, read-only.
  - Clears on start.
  - Increments (saturating at 16'hFFFF) each time idx wraps to 0 in loop mode.
- `TMR_SEQ_CNT_EN` undefined: no counter logic; 0x18 reads 0.

## Test plan
- Reset check: assert rstn low mid-WAIT → `m_we`=0, `irq`=0, SEQ_ST reads 0.
- Single pass, stimulus:
  - TPTR=0; TDATA 10, 20, 30; LEN=3; TCR=3'b111; CR=0x5 (start+ie).
  - Emulate `tmr_irq` pulses.
  - Required response:
    - Bus writes in order: RE=10, CR=7; then IR=0, RE=20; IR=0, RE=30; IR=0, CR=0.
    - done=1 and `irq`=1 after the third interrupt.
- Loop mode: LEN=2, loop=1, four `tmr_irq` pulses → RE writes 10, 20, 10, 20, 10; busy stays 1; with `TMR_SEQ_CNT_EN`, 0x18 reads 2.
- Abort in WAIT: write CR[3]=1 → next cycle CR=0 write, busy=0 the cycle after, done=0.
- LEN boundaries:
  - LEN=0 behaves as 1: one RE write, done after the first interrupt.
  - LEN=DEPTH+5 runs DEPTH steps.
- Start while busy is ignored (no new INIT_RE). Writing SEQ_ST[1]=1 clears done and drops `irq` next cycle.
